// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with handshake.
// Ports: clock, resetn, start, bin in; ready, done, bcd, sign, overflow, ndigits out.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH   = 16,
  parameter int BCD_DIGITS  = 5,
  parameter int SIGNED_MODE = 0,
  localparam int NDW = $clog2(BCD_DIGITS + 1),
  localparam int CW  = $clog2(BIN_WIDTH + 1),
  localparam int BW  = 4 * BCD_DIGITS
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 ready,
  output logic                 done,
  output logic [BW-1:0]        bcd,
  output logic                 sign,
  output logic                 overflow,
  output logic [NDW-1:0]       ndigits
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ADJUST,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        bcdw_q, bcdw_d;
  logic [BIN_WIDTH-1:0] binw_q, binw_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stk_q, stk_d;
  logic                 sgnw_q, sgnw_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  logic                 neg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      bcdw_q  <= '0;
      binw_q  <= '0;
      cnt_q   <= '0;
      stk_q   <= 1'b0;
      sgnw_q  <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcdw_q  <= bcdw_d;
      binw_q  <= binw_d;
      cnt_q   <= cnt_d;
      stk_q   <= stk_d;
      sgnw_q  <= sgnw_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  // A negative input is never zero, so the latched sign is
  // automatically 0 for a zero magnitude.
  assign neg = (SIGNED_MODE != 0) && bin[BIN_WIDTH-1];

  always_comb begin
    state_d = state_q;
    bcdw_d  = bcdw_q;
    binw_d  = binw_q;
    cnt_d   = cnt_q;
    stk_d   = stk_q;
    sgnw_d  = sgnw_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          binw_d  = neg ? (~bin + 1'b1) : bin;
          sgnw_d  = neg;
          bcdw_d  = '0;
          cnt_d   = '0;
          stk_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcdw_d = {bcdw_q[BW-2:0], binw_q[BIN_WIDTH-1]};
        binw_d = binw_q << 1;
        stk_d  = stk_q | bcdw_q[BW-1];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_d == CW'(BIN_WIDTH)) begin
          // Final shift: publish straight into the result registers.
          state_d = DONE;
          bcd_d   = bcdw_d;
          sign_d  = sgnw_q;
          ovf_d   = stk_d;
        end else begin
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
          if (bcdw_q[4*i +: 4] > 4'd4)
            bcdw_d[4*i +: 4] = bcdw_q[4*i +: 4] + 4'd3;
        end
        state_d = SHIFT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ndigits = NDW'(1);
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0)
        ndigits = NDW'(i + 1);
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign bcd      = bcd_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations, table vectors,
// scoreboard queues and hand-written reset / busy-start sequences.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: defaults
  logic        start0;
  logic [15:0] bin0;
  logic        ready0, done0, sign0, ovf0;
  logic [19:0] bcd0;
  logic [2:0]  nd0;
  // u1: 8-bit signed
  logic        start1;
  logic [7:0]  bin1;
  logic        ready1, done1, sign1, ovf1;
  logic [19:0] bcd1;
  logic [2:0]  nd1;
  // u2: 3 digits
  logic        start2;
  logic [15:0] bin2;
  logic        ready2, done2, sign2, ovf2;
  logic [11:0] bcd2;
  logic [1:0]  nd2;

  bin_to_bcd_seq u0 (
    .clock(clk), .resetn(resetn), .start(start0), .bin(bin0),
    .ready(ready0), .done(done0), .bcd(bcd0), .sign(sign0),
    .overflow(ovf0), .ndigits(nd0));

  bin_to_bcd_seq #(.BIN_WIDTH(8), .SIGNED_MODE(1)) u1 (
    .clock(clk), .resetn(resetn), .start(start1), .bin(bin1),
    .ready(ready1), .done(done1), .bcd(bcd1), .sign(sign1),
    .overflow(ovf1), .ndigits(nd1));

  bin_to_bcd_seq #(.BCD_DIGITS(3)) u2 (
    .clock(clk), .resetn(resetn), .start(start2), .bin(bin2),
    .ready(ready2), .done(done2), .bcd(bcd2), .sign(sign2),
    .overflow(ovf2), .ndigits(nd2));

  typedef struct {
    logic [39:0] bcd;
    logic        sgn;
    logic        ovf;
    int          nd;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    int          sel;
    logic [15:0] b;
    logic [39:0] bcd;
    logic        sgn;
    logic        ovf;
    int          nd;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   dcnt0 = 0;

  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spurious(string name);
    checks++;
    errors++;
    $display("FAIL %s: got done pulse expected none", name);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      dcnt0++;
      if (q0.size() == 0) spurious("done0");
      else begin
        e = q0.pop_front();
        chk("bcd0", 40'(bcd0), e.bcd);
        chk("sign0", 40'(sign0), 40'(e.sgn));
        chk("ovf0", 40'(ovf0), 40'(e.ovf));
        chk("nd0", 40'(nd0), 40'(e.nd));
        chk("lat0", 40'(cyc - e.acc), 40'(e.lat));
        chk("rdy_in_done0", 40'(ready0), 40'(0));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) spurious("done1");
      else begin
        e = q1.pop_front();
        chk("bcd1", 40'(bcd1), e.bcd);
        chk("sign1", 40'(sign1), 40'(e.sgn));
        chk("ovf1", 40'(ovf1), 40'(e.ovf));
        chk("nd1", 40'(nd1), 40'(e.nd));
        chk("lat1", 40'(cyc - e.acc), 40'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) spurious("done2");
      else begin
        e = q2.pop_front();
        chk("bcd2", 40'(bcd2), e.bcd);
        chk("sign2", 40'(sign2), 40'(e.sgn));
        chk("ovf2", 40'(ovf2), 40'(e.ovf));
        chk("nd2", 40'(nd2), 40'(e.nd));
        chk("lat2", 40'(cyc - e.acc), 40'(e.lat));
      end
    end
  end

  function automatic logic rdy(int s);
    case (s)
      0: return ready0;
      1: return ready1;
      default: return ready2;
    endcase
  endfunction

  task automatic drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL drain: got timeout expected done within 200");
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  // Accepts one conversion and waits for its result.
  task automatic run(int s, logic [15:0] b, logic [39:0] eb,
                     logic es, logic eo, int en, logic wait_done);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!rdy(s) && t < 200) begin
      @(negedge clk);
      t++;
    end
    case (s)
      0: begin bin0 = b; start0 = 1'b1; end
      1: begin bin1 = b[7:0]; start1 = 1'b1; end
      default: begin bin2 = b; start2 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    e.bcd = eb;
    e.sgn = es;
    e.ovf = eo;
    e.nd  = en;
    e.acc = cyc;
    e.lat = (s == 1) ? 15 : 31;
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    if (wait_done) begin
      drain();
      @(negedge clk);
      chk("ready_back", 40'(rdy(s)), 40'(1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   acc;
    int   d0;
    logic hold_bad;

    tbl[0] = '{0, 16'hFFFF, 40'h65535, 1'b0, 1'b0, 5};
    tbl[1] = '{0, 16'd0,    40'h00000, 1'b0, 1'b0, 1};
    tbl[2] = '{0, 16'd9,    40'h00009, 1'b0, 1'b0, 1};
    tbl[3] = '{0, 16'd10,   40'h00010, 1'b0, 1'b0, 2};
    tbl[4] = '{1, 16'h80,   40'h00128, 1'b1, 1'b0, 3};
    tbl[5] = '{1, 16'hFF,   40'h00001, 1'b1, 1'b0, 1};
    tbl[6] = '{1, 16'h7F,   40'h00127, 1'b0, 1'b0, 3};
    tbl[7] = '{2, 16'd1234, 40'h234,   1'b0, 1'b1, 3};
    tbl[8] = '{2, 16'd999,  40'h999,   1'b0, 1'b0, 3};
    tbl[9] = '{2, 16'd1000, 40'h000,   1'b0, 1'b1, 1};

    resetn = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 40'(ready0), 40'(1));
    chk("rst_done", 40'(done0), 40'(0));
    chk("rst_bcd", 40'(bcd0), 40'(0));
    chk("rst_sign", 40'(sign1), 40'(0));
    chk("rst_ovf", 40'(ovf2), 40'(0));
    chk("rst_nd", 40'(nd0), 40'(1));
    resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      run(tbl[i].sel, tbl[i].b, tbl[i].bcd, tbl[i].sgn,
          tbl[i].ovf, tbl[i].nd, 1'b1);

    // Reset in the middle of a conversion.
    run(0, 16'd4321, 40'h04321, 1'b0, 1'b0, 4, 1'b1);
    d0 = dcnt0;
    @(negedge clk);
    bin0 = 16'd777;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start0 = 1'b0;
    while (cyc < acc + 9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst_bcd", 40'(bcd0), 40'(0));
    chk("mid_rst_ready", 40'(ready0), 40'(1));
    chk("mid_rst_nd", 40'(nd0), 40'(1));
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", 40'(dcnt0 - d0), 40'(0));
    run(0, 16'd777, 40'h00777, 1'b0, 1'b0, 3, 1'b1);

    // start pulses while busy are ignored; bin changes are ignored.
    run(0, 16'd4321, 40'h04321, 1'b0, 1'b0, 4, 1'b1);
    d0 = dcnt0;
    hold_bad = 1'b0;
    run(0, 16'd500, 40'h00500, 1'b0, 1'b0, 3, 1'b0);
    acc = cyc;
    bin0 = 16'd42;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      start0 = (cyc == acc + 4) || (cyc == acc + 30);
      if (!done0 && cyc < acc + 31 && bcd0 !== 20'h04321)
        hold_bad = 1'b1;
    end
    start0 = 1'b0;
    chk("busy_hold", 40'(hold_bad), 40'(0));
    repeat (70) @(negedge clk);
    chk("busy_one_done", 40'(dcnt0 - d0), 40'(1));
    chk("busy_q_empty", 40'(q0.size()), 40'(0));
    chk("busy_bcd", 40'(bcd0), 40'h00500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method. It adds a ready/start/done handshake, optional two's-complement input, and overflow detection when BCD_DIGITS is undersized. It reports the significant-digit count for leading-zero blanking. It sits between the datapath and the 7-segment display driver.

Parameters:
BIN_WIDTH, 16, width of binary input (2..32).
BCD_DIGITS, 5, number of BCD output digits (1..10).
SIGNED_MODE, 0, 0 = input unsigned; 1 = input two's complement, converted as sign + magnitude.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  synchronous active-low reset.
start  in  1  request conversion; accepted only on a rising edge where ready=1.
bin  in  BIN_WIDTH  binary operand, sampled on the accept edge only.
ready  out  1  high only in IDLE.
done  out  1  one-cycle pulse: result registers have just been updated.
bcd  out  4*BCD_DIGITS  result; digit 0 is in bits [3:0].
sign  out  1  1 = negative input (SIGNED_MODE=1 only; otherwise constant 0).
overflow  out  1  result truncated: value is at least 10^BCD_DIGITS.
ndigits  out  clog2(BCD_DIGITS+1)  count of significant digits (1 for value 0).

Behaviour:
- Reset (resetn=0 at a rising edge), taking priority over everything, including mid-conversion:
  - State goes to IDLE; any in-flight conversion is abandoned.
  - Outputs: ready=1, done=0, bcd=0, sign=0, overflow=0, ndigits=1.
- States: IDLE, SHIFT, ADJUST, DONE. Internal registers: work BCD (4*BCD_DIGITS bits), work binary (BIN_WIDTH bits), bit counter, sticky overflow flag.
- IDLE:
  - If start=1, the edge is the accept edge:
    - Load the magnitude of bin: if SIGNED_MODE=1 and bin[MSB]=1, load -bin; otherwise load bin. -2^(BIN_WIDTH-1) yields magnitude 2^(BIN_WIDTH-1).
    - Latch the sign. Clear the work BCD, the counter and the sticky flag. Go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT:
  - Shift {work BCD, work binary} left by 1.
  - The bit leaving work BCD's MSB ORs into the sticky flag.
  - Increment the counter. If the counter reaches BIN_WIDTH, go to DONE; otherwise go to ADJUST.
- ADJUST: every digit of work BCD that is greater than 4 gets +3 (all digits in parallel, 4-bit result, no inter-digit carry). Then go to SHIFT.
- DONE:
  - On entry edge, copy work BCD to bcd, latched sign to sign, and the sticky flag to overflow.
  - done=1 for this single cycle; next edge returns to IDLE.
  - Exception: if the result magnitude is 0, sign is forced to 0.
- Latency: from the accept edge, done is high after exactly 2*BIN_WIDTH-1 further rising edges (31 for BIN_WIDTH=16). IDLE resumes on the next edge, so the accept-to-accept minimum is 2*BIN_WIDTH+1 edges.
- Outputs are registered:
  - bcd, sign and overflow hold their last result unchanged during a conversion, and change only on DONE entry or reset.
- ndigits: index of the highest nonzero digit of bcd, plus 1; equals 1 when bcd=0. Combinational from the bcd register.
- On overflow, bcd holds the low BCD_DIGITS digits of the true decimal value, which are exact.
- start while ready=0 (SHIFT/ADJUST/DONE) is ignored. No queuing, no effect on the current conversion.
- start held high continuously converts back-to-back. bin is re-sampled at each IDLE accept.
- bin changing after the accept edge has no effect.

Test Plan:
- Defaults, bin=16'hFFFF, start pulse: done is high 31 edges after the accept edge; bcd=20'h65535; overflow=0; ndigits=5; ready returns on the following cycle.
- bin=0: bcd=0, ndigits=1, overflow=0. Then bin=16'd9: bcd=20'h00009, ndigits=1. Then bin=16'd10: bcd=20'h00010, ndigits=2.
- SIGNED_MODE=1, BIN_WIDTH=8:
  - bin=8'h80 gives sign=1, bcd=20'h00128.
  - bin=8'hFF gives sign=1, bcd=20'h00001.
  - bin=8'h7F gives sign=0, bcd=20'h00127.
- BCD_DIGITS=3, bin=16'd1234: overflow=1, bcd=12'h234. Then bin=16'd999: overflow=0, bcd=12'h999.
- Convert 16'd4321 (bcd=20'h04321). Then start 16'd777 and assert resetn=0 for 1 cycle at edge 10:
  - No done pulse follows.
  - bcd=0, ready=1 after reset.
  - A new start with 16'd777 gives bcd=20'h00777.
- start with 16'd500, then pulse start with 16'd42 at edges 5 and 31 (both while ready=0):
  - Exactly one done; bcd=20'h00500; bcd held at 20'h04321 throughout the busy period.
